// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : fetch controller state encoding
//   FETCH_NOP     : instruction word used for a bubble
//   FETCH_ADDR_W  : default PC/address width
//   IF_ID_BUBBLE  : bubble value of the IF/ID bundle
package fetch_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] FETCH_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HELD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc4;
    logic                    valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: FETCH_NOP, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush/load/hold.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : load a bubble (wins over i_load)
//   i_load         : load {i_instr, i_pc4, valid=1}
//   o_instr/o_pc4/o_valid : registered IF/ID contents
// With neither strobe the register holds its value.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc4,
  output logic              o_valid
);

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= IF_ID_BUBBLE.instr;
      r_pc4   <= ADDR_W'(IF_ID_BUBBLE.pc4);
      r_valid <= IF_ID_BUBBLE.valid;
    end else if (i_flush) begin
      r_instr <= IF_ID_BUBBLE.instr;
      r_pc4   <= ADDR_W'(IF_ID_BUBBLE.pc4);
      r_valid <= IF_ID_BUBBLE.valid;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register, instruction-memory request handshake and
// IF/ID register, driven by the hazard unit's stall/flush/redirect outputs.
//   Clk, Reset (async, active-low)
//   PCWrite, IF_ID_Write, IF_ID_Flush, Redirect, RedirectTarget : hazard inputs
//   IMemReq, IMemAddr, IMemReady, IMemRdata : instruction-memory handshake
//   IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid : IF/ID register outputs
//   StallCycles, FlushCycles : event counters
// Optional feature macro: FETCH_STALL_COUNTER_EN enables the saturating
// stall/flush counters; when undefined both counter ports read 0.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              IF_ID_Flush,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectTarget,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemReady,
  input  logic [31:0]       IMemRdata,
  output logic [31:0]       IF_ID_Instruction,
  output logic [ADDR_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCycles
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [31:0]       r_hold_instr;
  logic [ADDR_W-1:0] r_hold_pc4;
  logic              w_hold_we;
  logic [ADDR_W-1:0] r_pending;
  logic              w_pend_we;
  logic              w_ifid_load;
  logic              w_ifid_flush;
  logic [31:0]       w_ifid_instr;
  logic [ADDR_W-1:0] w_ifid_pc4;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!IMemReady && Redirect)
          w_state_nxt = ST_DISCARD;
        else if (!Redirect && IMemReady && !IF_ID_Flush && (!IF_ID_Write || !PCWrite))
          w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (Redirect || IF_ID_Flush || (IF_ID_Write && PCWrite))
          w_state_nxt = ST_FETCH;
      end
      ST_DISCARD: begin
        if (IMemReady) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    IMemReq      = 1'b0;
    w_pc_nxt     = r_pc;
    w_hold_we    = 1'b0;
    w_pend_we    = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_ifid_instr = IMemRdata;
    w_ifid_pc4   = w_pc_plus4;
    unique case (r_state)
      ST_IDLE: ;
      ST_FETCH: begin
        IMemReq = 1'b1;
        if (!IMemReady && Redirect) begin
          // Request still in flight: keep the address stable and park the target.
          w_pend_we    = 1'b1;
          w_ifid_flush = 1'b1;
        end else if (Redirect) begin
          w_pc_nxt     = RedirectTarget;
          w_ifid_flush = 1'b1;
        end else if (IMemReady && IF_ID_Flush) begin
          w_ifid_flush = 1'b1;
          if (PCWrite) w_pc_nxt = w_pc_plus4;
        end else if (IMemReady && (!IF_ID_Write || !PCWrite)) begin
          // Park the word; IF/ID gets a bubble only if it is allowed to load.
          w_hold_we    = 1'b1;
          w_ifid_flush = IF_ID_Write;
        end else if (IMemReady) begin
          w_ifid_load = 1'b1;
          w_pc_nxt    = w_pc_plus4;
        end else begin
          w_ifid_flush = IF_ID_Write || IF_ID_Flush;
        end
      end
      ST_HELD: begin
        if (Redirect) begin
          w_pc_nxt = RedirectTarget;
        end else if (IF_ID_Flush) begin
          w_pc_nxt = w_pc_plus4;
        end else if (IF_ID_Write && PCWrite) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = r_hold_instr;
          w_ifid_pc4   = r_hold_pc4;
          w_pc_nxt     = w_pc_plus4;
        end
      end
      ST_DISCARD: begin
        IMemReq      = 1'b1;
        w_pend_we    = Redirect;
        w_ifid_flush = IF_ID_Write || IF_ID_Flush;
        // A redirect arriving with the stale response is the newest target.
        if (IMemReady) w_pc_nxt = Redirect ? RedirectTarget : r_pending;
      end
      default: ;
    endcase
  end

  assign IMemAddr = r_pc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc         <= RESET_PC;
      r_hold_instr <= FETCH_NOP;
      r_hold_pc4   <= '0;
      r_pending    <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_hold_we) begin
        r_hold_instr <= IMemRdata;
        r_hold_pc4   <= w_pc_plus4;
      end
      if (w_pend_we) r_pending <= RedirectTarget;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_flush (w_ifid_flush),
    .i_load  (w_ifid_load),
    .i_instr (w_ifid_instr),
    .i_pc4   (w_ifid_pc4),
    .o_instr (IF_ID_Instruction),
    .o_pc4   (IF_ID_PCPlus4),
    .o_valid (IF_ID_Valid)
  );

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite || r_state == ST_HELD) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (IF_ID_Flush || Redirect)        r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign StallCycles = r_stall_cnt;
  assign FlushCycles = r_flush_cnt;
`else
  assign StallCycles = '0;
  assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, Redirect;
  logic [31:0] RedirectTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRdata;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] StallCycles, FlushCycles;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_stall, exp_flush;

  always #5 Clk = ~Clk;

  // Memory returns a word tagged with its address.
  assign IMemRdata = 32'hC0DE_0000 | {16'h0, IMemAddr[15:0]};

  fetch_stage_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .PCWrite           (PCWrite),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Flush       (IF_ID_Flush),
    .Redirect          (Redirect),
    .RedirectTarget    (RedirectTarget),
    .IMemReq           (IMemReq),
    .IMemAddr          (IMemAddr),
    .IMemReady         (IMemReady),
    .IMemRdata         (IMemRdata),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .StallCycles       (StallCycles),
    .FlushCycles       (FlushCycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
`ifdef FETCH_STALL_COUNTER_EN
    exp_stall = 32'd5;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    Reset = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_ID_Flush = 1'b0;
    Redirect = 1'b0; RedirectTarget = 32'h0; IMemReady = 1'b1;
    #12;
    chk("rst_req",   {31'h0, IMemReq}, 32'h0);
    chk("rst_addr",  IMemAddr, 32'h0);
    chk("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("rst_instr", IF_ID_Instruction, 32'h0);
    chk("rst_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("rst_stall", StallCycles, 32'h0);
    chk("rst_flush", FlushCycles, 32'h0);
    Reset = 1'b1;

    // Sequential zero-wait fetch
    tick();
    chk("f0_req",   {31'h0, IMemReq}, 32'h1);
    chk("f0_addr",  IMemAddr, 32'h0);
    chk("f0_valid", {31'h0, IF_ID_Valid}, 32'h0);
    tick();
    chk("f1_pc4",   IF_ID_PCPlus4, 32'h4);
    chk("f1_instr", IF_ID_Instruction, 32'hC0DE_0000);
    chk("f1_valid", {31'h0, IF_ID_Valid}, 32'h1);
    chk("f1_addr",  IMemAddr, 32'h4);
    tick();
    chk("f2_pc4",   IF_ID_PCPlus4, 32'h8);
    chk("f2_addr",  IMemAddr, 32'h8);
    tick();
    chk("f3_pc4",   IF_ID_PCPlus4, 32'hC);
    chk("f3_addr",  IMemAddr, 32'hC);
    tick();
    chk("f4_addr",  IMemAddr, 32'h10);

    // Stall three cycles with the 0x10 word arriving
    IF_ID_Write = 1'b0; PCWrite = 1'b0;
    tick();
    chk("h0_req",   {31'h0, IMemReq}, 32'h0);
    chk("h0_pc4",   IF_ID_PCPlus4, 32'h10);
    tick();
    chk("h1_req",   {31'h0, IMemReq}, 32'h0);
    tick();
    chk("h2_req",   {31'h0, IMemReq}, 32'h0);
    chk("h2_addr",  IMemAddr, 32'h10);
    IF_ID_Write = 1'b1; PCWrite = 1'b1;
    tick();
    chk("hr_instr", IF_ID_Instruction, 32'hC0DE_0010);
    chk("hr_pc4",   IF_ID_PCPlus4, 32'h14);
    chk("hr_valid", {31'h0, IF_ID_Valid}, 32'h1);
    chk("hr_addr",  IMemAddr, 32'h14);
    chk("hr_req",   {31'h0, IMemReq}, 32'h1);
    tick(); tick(); tick();
    chk("pre_rd_addr", IMemAddr, 32'h20);

    // Zero-wait redirect to 0x40
    Redirect = 1'b1; RedirectTarget = 32'h40;
    tick();
    chk("rd_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("rd_instr", IF_ID_Instruction, 32'h0);
    chk("rd_addr",  IMemAddr, 32'h40);
    Redirect = 1'b0;
    tick();
    chk("rd_tinstr", IF_ID_Instruction, 32'hC0DE_0040);
    chk("rd_tpc4",   IF_ID_PCPlus4, 32'h44);
    chk("rd_tvalid", {31'h0, IF_ID_Valid}, 32'h1);

    // Redirect to 0x80 while the 0x44 fetch waits two cycles
    IMemReady = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h80;
    tick();
    chk("ds0_addr",  IMemAddr, 32'h44);
    chk("ds0_req",   {31'h0, IMemReq}, 32'h1);
    chk("ds0_valid", {31'h0, IF_ID_Valid}, 32'h0);
    Redirect = 1'b0; RedirectTarget = 32'h0;
    tick();
    chk("ds1_addr",  IMemAddr, 32'h44);
    IMemReady = 1'b1;
    tick();
    chk("ds2_addr",  IMemAddr, 32'h80);
    chk("ds2_valid", {31'h0, IF_ID_Valid}, 32'h0);
    tick();
    chk("ds3_instr", IF_ID_Instruction, 32'hC0DE_0080);
    chk("ds3_pc4",   IF_ID_PCPlus4, 32'h84);

    // PC+4 wrap at the top of the address space
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    tick();
    chk("wr_addr", IMemAddr, 32'hFFFF_FFFC);
    Redirect = 1'b0;
    tick();
    chk("wr_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("wr_valid", {31'h0, IF_ID_Valid}, 32'h1);
    chk("wr_instr", IF_ID_Instruction, 32'hC0DE_FFFC);
    chk("wr_addr2", IMemAddr, 32'h0);

    // Flush with a ready response: bubble, PC still advances
    IF_ID_Flush = 1'b1;
    tick();
    chk("fl_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("fl_addr",  IMemAddr, 32'h4);
    IF_ID_Flush = 1'b0;
    tick();
    chk("fl_pc4",   IF_ID_PCPlus4, 32'h8);

    // Async reset while HELD
    IF_ID_Write = 1'b0;
    tick();
    chk("rh_req",   {31'h0, IMemReq}, 32'h0);
    chk("rh_valid", {31'h0, IF_ID_Valid}, 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("ra_req",   {31'h0, IMemReq}, 32'h0);
    chk("ra_addr",  IMemAddr, 32'h0);
    chk("ra_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("ra_pc4",   IF_ID_PCPlus4, 32'h0);
    chk("ra_instr", IF_ID_Instruction, 32'h0);
    IF_ID_Write = 1'b1;
    #3 Reset = 1'b1;
    tick();
    chk("rs_addr", IMemAddr, 32'h0);
    chk("rs_req",  {31'h0, IMemReq}, 32'h1);
    tick();
    chk("rs_pc4",  IF_ID_PCPlus4, 32'h4);

    // Counter run: four PCWrite=0 cycles plus the HELD release cycle,
    // then one flush and one redirect.
    PCWrite = 1'b0;
    tick(); tick(); tick(); tick();
    PCWrite = 1'b1;
    tick();
    chk("cs_pc4",   IF_ID_PCPlus4, 32'h8);
    chk("cs_valid", {31'h0, IF_ID_Valid}, 32'h1);
    chk("cs_stall", StallCycles, exp_stall);
    IF_ID_Flush = 1'b1;
    tick();
    IF_ID_Flush = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h100;
    tick();
    Redirect = 1'b0;
    chk("cf_addr",  IMemAddr, 32'h100);
    chk("cf_flush", FlushCycles, exp_flush);
    tick();
    chk("ce_stall", StallCycles, exp_stall);
    chk("ce_flush", FlushCycles, exp_flush);
    chk("ce_pc4",   IF_ID_PCPlus4, 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

- Fetch-side consumer of the hazard unit's stall/flush/redirect outputs.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Applies `PCWrite`, `IF_ID_Write`, `IF_ID_Flush` and branch/jump redirects with fixed priority.
- Holds words fetched during a stall; discards in-flight fetches made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: PC/address width.
- `Clk`  in  1  core clock, all state on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `PCWrite`  in  1  1 = PC may advance.
- `IF_ID_Write`  in  1  1 = IF/ID may load.
- `IF_ID_Flush`  in  1  1 = IF/ID loads bubble.
- `Redirect`  in  1  branch/jump taken this cycle.
- `RedirectTarget`  in  ADDR_W  new PC when `Redirect`.
- `IMemReq`  out  1  fetch request.
- `IMemAddr`  out  ADDR_W  fetch address; equals PC.
- `IMemReady`  in  1  response valid this cycle.
- `IMemRdata`  in  32  instruction word, valid with `IMemReady`.
- `IF_ID_Instruction`  out  32  registered instruction.
- `IF_ID_PCPlus4`  out  ADDR_W  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  0 = bubble.
- `StallCycles`  out  32  stall counter.
- `FlushCycles`  out  32  flush counter.

## Operation
States: IDLE, FETCH, HELD, DISCARD.

- **Reset:** PC=`RESET_PC`, state IDLE, `IMemReq`=0, `IF_ID_Instruction`=0, `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0, counters=0, hold/pending registers cleared.
- **IDLE:** moves to FETCH on the next edge unconditionally.
- **FETCH:** `IMemReq`=1, `IMemAddr`=PC; `IMemAddr` stays stable until `IMemReady`. Per cycle, first match wins:
  1. `IMemReady`=0, `Redirect`=1: latch target into PendingTarget, go to DISCARD.
  2. `Redirect`=1: PC←`RedirectTarget`, IF/ID←bubble, stay in FETCH.
  3. `IMemReady`=1, `IF_ID_Flush`=1: IF/ID←bubble, word dropped, PC←PC+4 if `PCWrite`.
  4. `IMemReady`=1, `IF_ID_Write`=0 or `PCWrite`=0: word and PC+4 into hold register, go to HELD, PC unchanged.
  5. `IMemReady`=1 otherwise: IF/ID←{word, PC+4, valid}, PC←PC+4.
  6. `IMemReady`=0: IF/ID←bubble if `IF_ID_Write`=1, else IF/ID holds.
- **HELD:** `IMemReq`=0, IF/ID holds its value.
  - `Redirect`: drop the held word, PC←target, go to FETCH.
  - `IF_ID_Flush`: drop the held word, PC←PC+4, go to FETCH.
  - `IF_ID_Write` and `PCWrite` both 1: IF/ID←held word, PC←PC+4, go to FETCH.
- **DISCARD:** `IMemReq`=1 with the old address until `IMemReady`; that response is dropped.
  - On `IMemReady`: PC←PendingTarget, go to FETCH.
  - A later `Redirect` overwrites PendingTarget (last redirect wins).
- Bubble means instruction 32'h0, PCPlus4 0, valid 0.
- PC+4 wraps modulo 2^ADDR_W.

## Timing
- With zero-wait memory (`IMemReady` tied 1): one instruction per cycle; fetch at edge n appears on IF/ID after edge n.
- Redirect at cycle n: PC=target after edge n; target instruction valid on IF/ID after edge n+1.
- Stall release: the held word reaches IF/ID on the first edge with both write enables high. No re-fetch, no lost word.
- `Reset` asserts/deasserts asynchronously. Reset mid-DISCARD or mid-HELD abandons the transaction; memory must tolerate a dropped request.

## Configuration
- `FETCH_STALL_COUNTER_EN` defined:
  - `StallCycles` increments each cycle `PCWrite`=0 or state is HELD.
  - `FlushCycles` increments each cycle `IF_ID_Flush` or `Redirect` is 1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

## Structure
- Package `fetch_pkg` holds:
  - state enum
  - `FETCH_NOP` = 32'h0
  - default `ADDR_W`
  - bubble constant for the IF/ID bundle
- Sub-module `if_id_reg`: IF/ID register with load/flush/hold, async active-low reset.

## Test plan
- Reset release, `IMemReady`=1, `RESET_PC`=0 → `IMemAddr` 0,4,8 on consecutive cycles; IF/ID PCPlus4 4,8,12, valid=1.
- `IMemReady`=1 at PC=0x10 while `IF_ID_Write`=`PCWrite`=0 for 3 cycles → `IMemReq`=0 during hold; on release IF/ID gets the 0x10 word, PCPlus4=0x14; next fetch address 0x14.
- `Redirect`=1, target 0x40, during a zero-wait fetch at 0x20 → IF/ID bubble, then the 0x40 word with PCPlus4=0x44.
- `Redirect` to 0x80 with `IMemReady`=0 for 2 more cycles → `IMemAddr` stays at the old PC until ready; that word is never written to IF/ID; next request is 0x80.
- `Reset` low while in HELD → all outputs at reset values immediately; fetch restarts at `RESET_PC`.
- With `FETCH_STALL_COUNTER_EN`: 5 stall cycles and 2 flush cycles → `StallCycles`=5, `FlushCycles`=2; without the macro both read 0.
